// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared constants, flag type and combine helper for comparator_stream
//
// Purpose: default widths and the {lt, eq, gt} flag triple shared by the
// comparator top level and its half-width slice.
package comparator_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_COUNT_WIDTH = 8;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

  // The upper half decides the ordering unless it ties, then the lower half does.
  function automatic cmp_flags_t combine_flags(input cmp_flags_t hi, input cmp_flags_t lo);
    return hi.eq ? lo : hi;
  endfunction

endpackage

// File: rtl/comparator_slice.sv
// rtl/comparator_slice.sv - combinational unsigned compare of one operand slice
//
// Purpose: unsigned magnitude compare of two WIDTH-bit slices.
// Ports:
//   a_i     - slice of operand A
//   b_i     - slice of operand B
//   flags_o - {lt, eq, gt}; exactly one bit is set
module comparator_slice
  import comparator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output cmp_flags_t       flags_o
);

  always_comb begin
    flags_o    = FLAGS_NONE;
    flags_o.lt = (a_i < b_i);
    flags_o.eq = (a_i == b_i);
    flags_o.gt = (a_i > b_i);
  end

endmodule

// File: rtl/comparator_stream.sv
// rtl/comparator_stream.sv - 2-stage streaming signed/unsigned comparator with equal counter
//
// Purpose: compares operand pairs through a two-stage valid/ready pipeline.
// Stage 1 registers independent compares of the upper and lower operand
// halves; stage 2 registers the combined flag triple. Equal results that
// leave the block are counted with saturation.
// Ports:
//   Clock_In             - clock, rising edge
//   Reset_In             - asynchronous active-high reset
//   Valid_In / Ready_Out - input handshake
//   Signed_Mode_In       - 1: two's-complement compare, 0: unsigned
//   Data_A_In, Data_B_In - operands
//   Valid_Out / Ready_In - output handshake
//   A_Less_Than_B_Out, A_Equal_To_B_Out, A_Greater_Than_B_Out - result flags
//   Clear_Count_In       - synchronous clear of the equal counter
//   Equal_Count_Out      - saturating count of delivered equal results
module comparator_stream
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Valid_In,
  output logic                   Ready_Out,
  input  logic                   Signed_Mode_In,
  input  logic [DATA_WIDTH-1:0]  Data_A_In,
  input  logic [DATA_WIDTH-1:0]  Data_B_In,
  output logic                   Valid_Out,
  input  logic                   Ready_In,
  output logic                   A_Less_Than_B_Out,
  output logic                   A_Equal_To_B_Out,
  output logic                   A_Greater_Than_B_Out,
  input  logic                   Clear_Count_In,
  output logic [COUNT_WIDTH-1:0] Equal_Count_Out
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Inverting the MSBs maps two's-complement order onto unsigned order.
  // Only the upper slice holds the MSB, so the mode touches only that slice.
  logic [DATA_WIDTH-1:0] a_adj;
  logic [DATA_WIDTH-1:0] b_adj;

  always_comb begin
    a_adj = Data_A_In;
    b_adj = Data_B_In;
    a_adj[DATA_WIDTH-1] = Data_A_In[DATA_WIDTH-1] ^ Signed_Mode_In;
    b_adj[DATA_WIDTH-1] = Data_B_In[DATA_WIDTH-1] ^ Signed_Mode_In;
  end

  cmp_flags_t hi_cmp;
  cmp_flags_t lo_cmp;

  comparator_slice #(.WIDTH(HALF)) u_slice_hi (
    .a_i     (a_adj[DATA_WIDTH-1:HALF]),
    .b_i     (b_adj[DATA_WIDTH-1:HALF]),
    .flags_o (hi_cmp)
  );

  comparator_slice #(.WIDTH(HALF)) u_slice_lo (
    .a_i     (a_adj[HALF-1:0]),
    .b_i     (b_adj[HALF-1:0]),
    .flags_o (lo_cmp)
  );

  logic                   s1_valid_q, s1_valid_d;
  cmp_flags_t             s1_hi_q, s1_hi_d;
  cmp_flags_t             s1_lo_q, s1_lo_d;
  logic                   s2_valid_q, s2_valid_d;
  cmp_flags_t             s2_flags_q, s2_flags_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic s1_adv;
  logic s2_adv;
  logic out_xfer;

  always_comb begin
    s2_adv   = !s2_valid_q || Ready_In;
    s1_adv   = !s1_valid_q || s2_adv;
    out_xfer = s2_valid_q && Ready_In;

    s1_valid_d = s1_valid_q;
    s1_hi_d    = s1_hi_q;
    s1_lo_d    = s1_lo_q;
    s2_valid_d = s2_valid_q;
    s2_flags_d = s2_flags_q;
    count_d    = count_q;

    if (s1_adv) begin
      s1_valid_d = Valid_In;
      s1_hi_d    = hi_cmp;
      s1_lo_d    = lo_cmp;
    end

    // An empty slot moving into stage 2 forces the flags low so they are
    // all zero whenever Valid_Out is low.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_flags_d = s1_valid_q ? combine_flags(s1_hi_q, s1_lo_q) : FLAGS_NONE;
    end

    if (Clear_Count_In) begin
      count_d = '0;
    end else if (out_xfer && s2_flags_q.eq && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      s1_valid_q <= 1'b0;
      s1_hi_q    <= FLAGS_NONE;
      s1_lo_q    <= FLAGS_NONE;
      s2_valid_q <= 1'b0;
      s2_flags_q <= FLAGS_NONE;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hi_q    <= s1_hi_d;
      s1_lo_q    <= s1_lo_d;
      s2_valid_q <= s2_valid_d;
      s2_flags_q <= s2_flags_d;
      count_q    <= count_d;
    end
  end

  assign Ready_Out            = s1_adv;
  assign Valid_Out            = s2_valid_q;
  assign A_Less_Than_B_Out    = s2_flags_q.lt;
  assign A_Equal_To_B_Out     = s2_flags_q.eq;
  assign A_Greater_Than_B_Out = s2_flags_q.gt;
  assign Equal_Count_Out      = count_q;

endmodule

// File: tb/tb_comparator_stream.sv
// tb/tb_comparator_stream.sv - directed self-checking bench for comparator_stream
module tb_comparator_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_in = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       ready_in = 1'b1;
  logic       clear = 1'b0;

  logic       ready_out, valid_out, lt, eq, gt;
  logic [7:0] cnt;
  logic       s_ready_out, s_valid_out, s_lt, s_eq, s_gt;
  logic [1:0] s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comparator_stream #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
    .Clock_In             (clk),
    .Reset_In             (rst),
    .Valid_In             (valid_in),
    .Ready_Out            (ready_out),
    .Signed_Mode_In       (signed_mode),
    .Data_A_In            (a),
    .Data_B_In            (b),
    .Valid_Out            (valid_out),
    .Ready_In             (ready_in),
    .A_Less_Than_B_Out    (lt),
    .A_Equal_To_B_Out     (eq),
    .A_Greater_Than_B_Out (gt),
    .Clear_Count_In       (clear),
    .Equal_Count_Out      (cnt)
  );

  comparator_stream #(.DATA_WIDTH(8), .COUNT_WIDTH(2)) dut_sat (
    .Clock_In             (clk),
    .Reset_In             (rst),
    .Valid_In             (valid_in),
    .Ready_Out            (s_ready_out),
    .Signed_Mode_In       (signed_mode),
    .Data_A_In            (a),
    .Data_B_In            (b),
    .Valid_Out            (s_valid_out),
    .Ready_In             (ready_in),
    .A_Less_Than_B_Out    (s_lt),
    .A_Equal_To_B_Out     (s_eq),
    .A_Greater_Than_B_Out (s_gt),
    .Clear_Count_In       (clear),
    .Equal_Count_Out      (s_cnt)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    clear    = 1'b0;
    ready_in = 1'b1;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000", {valid_out, lt, eq, gt});
    end
    total++;
    if (cnt !== 8'd0 || s_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d/%0d want 0/0", cnt, s_cnt);
    end
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", ready_out);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: ready=%b valid=%b want 1/0", ready_out, valid_out);
    end
  endtask

  task automatic test_mode();
    ready_in = 1'b1;
    valid_in = 1'b1; a = 8'h80; b = 8'h7F; signed_mode = 1'b0;
    step();
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b0000) begin
      bad++;
      $display("FAIL mode_latency1: got %b want 0000", {valid_out, lt, eq, gt});
    end
    signed_mode = 1'b1;
    step();
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b1001) begin
      bad++;
      $display("FAIL mode_unsigned_gt: got %b want 1001", {valid_out, lt, eq, gt});
    end
    valid_in = 1'b0; signed_mode = 1'b0;
    step();
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b1100) begin
      bad++;
      $display("FAIL mode_signed_lt: got %b want 1100", {valid_out, lt, eq, gt});
    end
    step();
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b0000) begin
      bad++;
      $display("FAIL mode_drain: got %b want 0000", {valid_out, lt, eq, gt});
    end
  endtask

  task automatic test_equal_stream();
    ready_in = 1'b1;
    valid_in = 1'b1; a = 8'h3C; b = 8'h3C; signed_mode = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) valid_in = 1'b0;
      total++;
      if ({valid_out, lt, eq, gt} !== 4'b1010) begin
        bad++;
        $display("FAIL eq_stream_%0d: got %b want 1010", i, {valid_out, lt, eq, gt});
      end
      step();
    end
    total++;
    if (valid_out !== 1'b0 || cnt !== 8'd3) begin
      bad++;
      $display("FAIL eq_stream_count: valid=%b cnt=%0d want 0/3", valid_out, cnt);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    valid_in = 1'b1; a = 8'd1; b = 8'd2;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_first: got %b want 1", ready_out);
    end
    step();
    a = 8'd5; b = 8'd5;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_second: got %b want 1", ready_out);
    end
    step();
    a = 8'd9; b = 8'd3;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ready_out !== 1'b0 || {valid_out, lt, eq, gt} !== 4'b1100) begin
        bad++;
        $display("FAIL bp_hold_%0d: ready=%b out=%b want 0/1100", i, ready_out, {valid_out, lt, eq, gt});
      end
      step();
    end
    ready_in = 1'b1;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 1", ready_out);
    end
    step();
    valid_in = 1'b0;
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b1010) begin
      bad++;
      $display("FAIL bp_second_eq: got %b want 1010", {valid_out, lt, eq, gt});
    end
    step();
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b1001 || cnt !== 8'd4) begin
      bad++;
      $display("FAIL bp_third_gt: out=%b cnt=%0d want 1001/4", {valid_out, lt, eq, gt}, cnt);
    end
    step();
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: got %b want 0", valid_out);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    valid_in = 1'b1; a = 8'hA5; b = 8'hA5; signed_mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (s_cnt !== 2'd3) begin
      bad++;
      $display("FAIL sat_count: got %0d want 3", s_cnt);
    end
    total++;
    if (cnt !== 8'd5) begin
      bad++;
      $display("FAIL sat_wide_count: got %0d want 5", cnt);
    end
  endtask

  task automatic test_clear_collision();
    valid_in = 1'b1; a = 8'h11; b = 8'h11; signed_mode = 1'b0;
    step();
    valid_in = 1'b0;
    step();
    total++;
    if ({valid_out, eq} !== 2'b11) begin
      bad++;
      $display("FAIL clear_pre: got %b want 11", {valid_out, eq});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if (cnt !== 8'd0 || s_cnt !== 2'd0 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL clear_collision: cnt=%0d sat=%0d valid=%b want 0/0/0", cnt, s_cnt, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b1;
    valid_in = 1'b1; a = 8'h42; b = 8'h42;
    step();
    step();
    step();
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || cnt !== 8'd1) begin
      bad++;
      $display("FAIL rst_mid_pre: valid=%b cnt=%0d want 1/1", valid_out, cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({valid_out, lt, eq, gt} !== 4'b0000 || cnt !== 8'd0 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_async: out=%b cnt=%0d ready=%b want 0000/0/1", {valid_out, lt, eq, gt}, cnt, ready_out);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (valid_out !== 1'b0 || cnt !== 8'd0) begin
        bad++;
        $display("FAIL rst_mid_after_%0d: valid=%b cnt=%0d want 0/0", i, valid_out, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_equal_stream();
    test_backpressure();
    test_saturation();
    test_clear_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_stream.md
COMPARATOR_STREAM -- requirements
Module: comparator_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand width in bits (even, >= 4).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 8, width of the equal-result counter.
REQ-003 The block SHALL have port Clock_In  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset_In  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port Valid_In  input  1  input operand pair valid.
REQ-006 The block SHALL have port Ready_Out  output  1  block can accept an operand pair this cycle.
REQ-007 The block SHALL have port Signed_Mode_In  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
REQ-008 The block SHALL have port Data_A_In  input  DATA_WIDTH  operand A.
REQ-009 The block SHALL have port Data_B_In  input  DATA_WIDTH  operand B.
REQ-010 The block SHALL have port Valid_Out  output  1  result valid.
REQ-011 The block SHALL have port Ready_In  input  1  downstream accepts the result.
REQ-012 The block SHALL have port A_Less_Than_B_Out  output  1  result flag A<B.
REQ-013 The block SHALL have port A_Equal_To_B_Out  output  1  result flag A==B.
REQ-014 The block SHALL have port A_Greater_Than_B_Out  output  1  result flag A>B.
REQ-015 The block SHALL have port Clear_Count_In  input  1  synchronous clear of the equal counter.
REQ-016 The block SHALL have port Equal_Count_Out  output  COUNT_WIDTH  count of transferred equal results.

Function
REQ-017 The block SHALL accept an input transfer when Valid_In and Ready_Out are both 1 on a rising edge.
REQ-018 The block SHALL deliver an output transfer when Valid_Out and Ready_In are both 1 on a rising edge.
REQ-019 The block SHALL be a 2-stage pipeline:
- stage 1 registers independent compare results of the upper and lower operand halves;
- stage 2 registers the combined flags.
REQ-020 Latency from input transfer to Valid_Out SHALL be exactly 2 cycles when Ready_In is held at 1.
REQ-021 Throughput SHALL be one transfer per cycle when Ready_In is held at 1.
REQ-022 The stall rules SHALL be:
- stage 2 advances when it is empty or Ready_In = 1;
- stage 1 advances when it is empty or stage 2 advances;
- Ready_Out = stage-1 advance condition, derived combinationally from the valids and Ready_In.
REQ-023 While Valid_Out = 1 and Ready_In = 0, all outputs other than Equal_Count_Out SHALL remain stable, and no data SHALL be lost, duplicated or reordered.
REQ-024 Exactly one of the three flags SHALL be 1 whenever Valid_Out = 1, and all three SHALL be 0 whenever Valid_Out = 0.
REQ-025 Signed mode SHALL compare as two's complement: operand MSBs are inverted, then an unsigned compare is done. Mode travels with its own transaction.
REQ-026 Combining rule: the upper half decides unless the upper halves are equal, in which case the lower half decides.
REQ-027 Equal_Count_Out SHALL increment by 1 on each output transfer with A_Equal_To_B_Out = 1.
REQ-028 Equal_Count_Out SHALL saturate at 2^COUNT_WIDTH-1 and SHALL NOT wrap.
REQ-029 Clear_Count_In SHALL set Equal_Count_Out to 0 on the next edge. Clear SHALL win over a simultaneous increment, giving 0.
REQ-030 Simultaneous input and output transfers in the same cycle SHALL both complete.

Reset
REQ-031 On Reset_In = 1 the block SHALL immediately clear both stage valids, all flags and Equal_Count_Out to 0, without waiting for a clock edge.
REQ-032 Ready_Out SHALL be 1 while reset is asserted and after release.
REQ-033 Reset mid-operation SHALL discard all in-flight transactions, and none SHALL emerge after release.

Structure
REQ-034 Package comparator_pkg SHALL hold:
- the default DATA_WIDTH and COUNT_WIDTH constants;
- a packed struct type for the {lt, eq, gt} flag triple.
REQ-035 Sub-module comparator_slice SHALL be a combinational unsigned compare of one half-width slice producing the flag triple. It SHALL be instantiated twice in stage 1.
REQ-036 The top level SHALL contain the pipeline registers, the handshake logic and the counter.

Verification (DATA_WIDTH=8)
REQ-037 Mode check: A=0x80, B=0x7F, Signed=0, then the same operands with Signed=1 back-to-back -> GT then LT on consecutive cycles, each 2 cycles after its input.
REQ-038 Equal streaming: three back-to-back pairs A=B=0x3C with Ready_In=1 -> Valid_Out high for 3 consecutive cycles with EQ set, then Equal_Count_Out=3.
REQ-039 Backpressure: Ready_In=0 with continuous Valid_In, pairs (1,2),(5,5),(9,3) -> Ready_Out falls after 2 accepts and outputs are held. Raising Ready_In then yields LT, EQ, GT in order.
REQ-040 Saturation: COUNT_WIDTH=2 with 5 equal results -> Equal_Count_Out=3.
REQ-041 Clear collision: Clear_Count_In asserted on the same edge as an equal output transfer -> Equal_Count_Out=0.
REQ-042 Reset mid-operation: assert Reset_In with 2 transactions in flight -> Valid_Out=0 and count=0 immediately, and no output appears after release.
